jls_scan_ctrl: RTL and testbench
================================

JLS_SCAN_CTRL -- requirements
Module: jls_scan_ctrl

Interface
REQ-001 SHALL have parameter IMG_W, default 512, meaning pixels per line (1..65535).
REQ-002 SHALL have parameter IMG_H, default 512, meaning lines per frame (1..65535).
REQ-003 SHALL have parameter PIX_W, default 16, meaning pixel sample width.
REQ-004 SHALL have parameter LINE_GAP, default 2, meaning stall cycles inserted between lines for line-buffer turnaround (0..15).
REQ-005 SHALL have port clk  in  1  clock, all logic rising-edge.
REQ-006 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-007 SHALL have port start  in  1  frame start request, sampled in IDLE only.
REQ-008 SHALL have port s_valid  in  1  upstream pixel valid.
REQ-009 SHALL have port s_pixel  in  PIX_W  upstream pixel sample.
REQ-010 SHALL have port s_ready  out  1  upstream accept; a transfer occurs when s_valid and s_ready are both 1.
REQ-011 SHALL have port pix_en  out  1  pixel strobe to the neighbour-context datapath (its data_en).
REQ-012 SHALL have port pix_data  out  PIX_W  pixel to the datapath, valid with pix_en.
REQ-013 SHALL have ports sol, eol, first_row, last_row  out  1 each  position flags qualified by pix_en.
REQ-014 SHALL have ports col, row  out  16 each  coordinates of the pixel on pix_data.
REQ-015 SHALL have ports busy  out  1  (state != IDLE) and frame_done  out  1  (single-cycle pulse).

Function
REQ-016 SHALL implement FSM states IDLE, LINE, GAP, DONE.
REQ-017 IDLE: s_ready=0; start=1 -> LINE with internal col/row counters cleared to 0.
REQ-018 LINE: s_ready=1; each transfer advances the column counter; transfer at column IMG_W-1 -> DONE if row IMG_H-1, else GAP (LINE_GAP>0) or LINE (LINE_GAP=0), column cleared, row incremented.
REQ-019 GAP: s_ready=0 for exactly LINE_GAP cycles, then LINE.
REQ-020 DONE: s_ready=0, frame_done=1 for one cycle, then IDLE.
REQ-021 Each transfer SHALL produce pix_en=1 exactly one cycle later with registered pix_data, col, row and flags; no transfer -> pix_en=0 and pix_data/col/row hold.
REQ-022 sol=1 iff col=0, eol=1 iff col=IMG_W-1, first_row=1 iff row=0, last_row=1 iff row=IMG_H-1; all forced 0 when pix_en=0.
REQ-023 IMG_W=1 SHALL assert sol and eol on every pixel; IMG_H=1 SHALL assert first_row and last_row on every pixel.
REQ-024 frame_done SHALL coincide with pix_en of the final pixel (col IMG_W-1, row IMG_H-1).
REQ-025 start while busy=1 SHALL be ignored; start in the DONE cycle SHALL be ignored.
REQ-026 s_valid deasserted mid-line SHALL stall counters without state change; no pixel lost or duplicated.

Reset
REQ-027 rst_n=0 SHALL asynchronously force IDLE, counters 0, and all outputs 0 (s_ready, pix_en, pix_data, flags, col, row, busy, frame_done).
REQ-028 Reset mid-frame SHALL abandon the frame; no frame_done issued; next frame requires new start.

Configuration
REQ-029 Macro JLS_SCAN_CTRL_FRAME_CNT_EN defined: extra port frame_cnt  out  16, reset 0, incremented with each frame_done, wraps 65535->0.
REQ-030 Macro undefined: frame_cnt port and counter absent; all other behaviour identical.

Structure
REQ-031 Package jls_pkg SHALL hold the FSM state enum, default IMG_W/IMG_H/PIX_W constants, and the 16-bit coordinate type.
REQ-032 Column/row counting SHALL live in sub-module jls_pos_cnt (inputs: clear, advance; outputs: col, row, end_of_line, end_of_frame).

Verification
REQ-033 IMG_W=4, IMG_H=3, LINE_GAP=2, s_valid constantly 1, pixels 1..12 -> 12 pix_en pulses with pix_data 1..12, s_ready low 2 cycles after pixels 4 and 8, sol on 1/5/9, eol on 4/8/12, frame_done with pixel 12.
REQ-034 Same config, s_valid toggling 1,0,1,0 -> pix_en only after each accepted pixel, col/row sequence unchanged, 12 pixels total.
REQ-035 start pulsed during row 1 -> ignored; frame completes normally with one frame_done.
REQ-036 rst_n low after pixel 6 -> all outputs 0 within the reset cycle, IDLE; new start restarts at col 0 row 0 with pixel 1.
REQ-037 IMG_W=1, IMG_H=1 -> single pix_en with sol, eol, first_row, last_row, frame_done all 1.
REQ-038 JLS_SCAN_CTRL_FRAME_CNT_EN defined, frame_cnt preloaded via force to 65535 -> next frame_done yields frame_cnt 0.

Source files
------------

// File: rtl/jls_pkg.sv
// Shared types and defaults for the JPEG-LS scan controller slice.
//   scan_state_e : scan FSM encoding (IDLE, LINE, GAP, DONE)
//   coord_t      : 16-bit pixel coordinate (column / row)
//   DEF_*        : default image geometry and sample width
package jls_pkg;

  localparam int unsigned DEF_IMG_W = 512;
  localparam int unsigned DEF_IMG_H = 512;
  localparam int unsigned DEF_PIX_W = 16;
  localparam int unsigned COORD_W   = 16;

  typedef logic [COORD_W-1:0] coord_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LINE = 2'd1,
    ST_GAP  = 2'd2,
    ST_DONE = 2'd3
  } scan_state_e;

endpackage

// File: rtl/jls_scan_ctrl_if.sv
// Upstream pixel stream into the scan controller.
//   s_valid : source has a pixel on s_pixel
//   s_pixel : pixel sample, PIX_W bits
//   s_ready : controller accepts
// Handshake: a pixel transfers on a rising clk edge where s_valid and
// s_ready are both 1. s_ready depends only on controller state, never on
// s_valid, and the source keeps s_pixel stable while s_valid is 1 and not
// yet accepted.
interface jls_scan_ctrl_if #(
  parameter int unsigned PIX_W = 16
);
  logic             s_valid;
  logic [PIX_W-1:0] s_pixel;
  logic             s_ready;

  modport master (output s_valid, output s_pixel, input  s_ready);
  modport slave  (input  s_valid, input  s_pixel, output s_ready);
endinterface

// File: rtl/jls_pos_cnt.sv
// Raster position counter for the scan controller.
//   clk, rst_n   : clock, asynchronous active-low reset
//   clear        : zero column and row (frame start)
//   advance      : one pixel consumed; step column, wrap into next row
//   col, row     : position of the pixel about to be consumed
//   end_of_line  : col is the last column
//   end_of_frame : col/row is the last pixel of the frame
module jls_pos_cnt
  import jls_pkg::*;
#(
  parameter int unsigned IMG_W = DEF_IMG_W,
  parameter int unsigned IMG_H = DEF_IMG_H
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   clear,
  input  logic   advance,
  output coord_t col,
  output coord_t row,
  output logic   end_of_line,
  output logic   end_of_frame
);

  localparam coord_t LAST_COL = coord_t'(IMG_W - 1);
  localparam coord_t LAST_ROW = coord_t'(IMG_H - 1);

  coord_t col_q, col_d;
  coord_t row_q, row_d;

  assign end_of_line  = (col_q == LAST_COL);
  assign end_of_frame = end_of_line && (row_q == LAST_ROW);

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (clear) begin
      col_d = '0;
      row_d = '0;
    end else if (advance) begin
      if (end_of_line) begin
        col_d = '0;
        // Wrap to the origin after the last pixel so an idle counter is clean.
        row_d = end_of_frame ? '0 : row_q + coord_t'(1);
      end else begin
        col_d = col_q + coord_t'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end

  assign col = col_q;
  assign row = row_q;

endmodule

// File: rtl/jls_scan_ctrl.sv
// JPEG-LS raster scan controller: accepts pixels from an upstream stream,
// inserts LINE_GAP stall cycles between lines, and presents each accepted
// pixel one cycle later with its coordinates and position flags.
//   clk, rst_n        : clock, asynchronous active-low reset
//   start             : frame start request (honoured in IDLE only)
//   s_if              : upstream stream (s_valid, s_pixel, s_ready)
//   pix_en, pix_data  : pixel strobe and sample to the context datapath
//   sol, eol          : first / last column flags (0 when pix_en=0)
//   first_row, last_row : first / last row flags (0 when pix_en=0)
//   col, row          : coordinates of pix_data (hold when pix_en=0)
//   busy              : FSM not in IDLE
//   frame_done        : one-cycle pulse with the final pixel's pix_en
//   frame_cnt         : frames completed, wraps (JLS_SCAN_CTRL_FRAME_CNT_EN only)
//   dbg_state_o       : current FSM state
// Build option: define JLS_SCAN_CTRL_FRAME_CNT_EN to add frame_cnt.
module jls_scan_ctrl
  import jls_pkg::*;
#(
  parameter int unsigned IMG_W    = DEF_IMG_W,
  parameter int unsigned IMG_H    = DEF_IMG_H,
  parameter int unsigned PIX_W    = DEF_PIX_W,
  parameter int unsigned LINE_GAP = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  jls_scan_ctrl_if.slave   s_if,
  output logic             pix_en,
  output logic [PIX_W-1:0] pix_data,
  output logic             sol,
  output logic             eol,
  output logic             first_row,
  output logic             last_row,
  output coord_t           col,
  output coord_t           row,
  output logic             busy,
  output logic             frame_done,
`ifdef JLS_SCAN_CTRL_FRAME_CNT_EN
  output logic [15:0]      frame_cnt,
`endif
  output scan_state_e      dbg_state_o
);

  localparam coord_t     LAST_ROW = coord_t'(IMG_H - 1);
  localparam logic [3:0] GAP_LAST = 4'((LINE_GAP == 0) ? 0 : LINE_GAP - 1);

  scan_state_e state_q, state_d;
  logic [3:0]  gap_q, gap_d;
  logic        clear_pos;
  logic        xfer;
  coord_t      cnt_col, cnt_row;
  logic        cnt_eol, cnt_eof;

  logic             pix_en_q;
  logic [PIX_W-1:0] pix_data_q;
  coord_t           col_q, row_q;
  logic             sol_q, eol_q, first_q, last_q;

  assign s_if.s_ready = (state_q == ST_LINE);
  assign xfer         = s_if.s_valid && s_if.s_ready;

  jls_pos_cnt #(
    .IMG_W(IMG_W),
    .IMG_H(IMG_H)
  ) u_pos_cnt (
    .clk         (clk),
    .rst_n       (rst_n),
    .clear       (clear_pos),
    .advance     (xfer),
    .col         (cnt_col),
    .row         (cnt_row),
    .end_of_line (cnt_eol),
    .end_of_frame(cnt_eof)
  );

  always_comb begin
    state_d   = state_q;
    gap_d     = gap_q;
    clear_pos = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d   = ST_LINE;
          clear_pos = 1'b1;
        end
      end
      ST_LINE: begin
        if (xfer && cnt_eol) begin
          if (cnt_eof) begin
            state_d = ST_DONE;
          end else if (LINE_GAP != 0) begin
            state_d = ST_GAP;
            gap_d   = '0;
          end
        end
      end
      ST_GAP: begin
        if (gap_q == GAP_LAST) state_d = ST_LINE;
        else                   gap_d   = gap_q + 4'd1;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      gap_q      <= '0;
      pix_en_q   <= 1'b0;
      pix_data_q <= '0;
      col_q      <= '0;
      row_q      <= '0;
      sol_q      <= 1'b0;
      eol_q      <= 1'b0;
      first_q    <= 1'b0;
      last_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      gap_q    <= gap_d;
      pix_en_q <= xfer;
      // Sample and coordinates hold between strobes; flags are strobe-qualified.
      if (xfer) begin
        pix_data_q <= s_if.s_pixel;
        col_q      <= cnt_col;
        row_q      <= cnt_row;
      end
      sol_q   <= xfer && (cnt_col == '0);
      eol_q   <= xfer && cnt_eol;
      first_q <= xfer && (cnt_row == '0);
      last_q  <= xfer && (cnt_row == LAST_ROW);
    end
  end

  assign pix_en      = pix_en_q;
  assign pix_data    = pix_data_q;
  assign col         = col_q;
  assign row         = row_q;
  assign sol         = sol_q;
  assign eol         = eol_q;
  assign first_row   = first_q;
  assign last_row    = last_q;
  assign busy        = (state_q != ST_IDLE);
  // DONE is entered on the final transfer, so it lines up with that pixel's strobe.
  assign frame_done  = (state_q == ST_DONE);
  assign dbg_state_o = state_q;

`ifdef JLS_SCAN_CTRL_FRAME_CNT_EN
  logic [15:0] frame_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          frame_cnt_q <= '0;
    else if (frame_done) frame_cnt_q <= frame_cnt_q + 16'd1;
  end

  assign frame_cnt = frame_cnt_q;
`endif

endmodule

// File: tb/tb_jls_scan_ctrl.sv
// Bench for jls_scan_ctrl: a 4x3 instance (LINE_GAP=2) driven through
// directed frames, plus a 1x1 instance for the single-pixel frame.
module tb_jls_scan_ctrl;
  import jls_pkg::*;

  localparam int W = 54;  // {pix_en, data16, col16, row16, sol, eol, first, last, frame_done}

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT A: 4x3, gap 2 ----------------
  jls_scan_ctrl_if #(.PIX_W(16)) a_if ();
  logic        a_start;
  logic        a_pix_en, a_sol, a_eol, a_first, a_last, a_busy, a_frame_done;
  logic [15:0] a_pix_data;
  coord_t      a_col, a_row;
  scan_state_e a_state;
`ifdef JLS_SCAN_CTRL_FRAME_CNT_EN
  logic [15:0] a_frame_cnt;
`endif

  jls_scan_ctrl #(.IMG_W(4), .IMG_H(3), .PIX_W(16), .LINE_GAP(2)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(a_start), .s_if(a_if.slave),
    .pix_en(a_pix_en), .pix_data(a_pix_data), .sol(a_sol), .eol(a_eol),
    .first_row(a_first), .last_row(a_last), .col(a_col), .row(a_row),
    .busy(a_busy), .frame_done(a_frame_done),
`ifdef JLS_SCAN_CTRL_FRAME_CNT_EN
    .frame_cnt(a_frame_cnt),
`endif
    .dbg_state_o(a_state)
  );

  // ---------------- DUT B: 1x1 ----------------
  jls_scan_ctrl_if #(.PIX_W(16)) b_if ();
  logic        b_start;
  logic        b_pix_en, b_sol, b_eol, b_first, b_last, b_busy, b_frame_done;
  logic [15:0] b_pix_data;
  coord_t      b_col, b_row;
  scan_state_e b_state;
`ifdef JLS_SCAN_CTRL_FRAME_CNT_EN
  logic [15:0] b_frame_cnt;
`endif

  jls_scan_ctrl #(.IMG_W(1), .IMG_H(1), .PIX_W(16), .LINE_GAP(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(b_start), .s_if(b_if.slave),
    .pix_en(b_pix_en), .pix_data(b_pix_data), .sol(b_sol), .eol(b_eol),
    .first_row(b_first), .last_row(b_last), .col(b_col), .row(b_row),
    .busy(b_busy), .frame_done(b_frame_done),
`ifdef JLS_SCAN_CTRL_FRAME_CNT_EN
    .frame_cnt(b_frame_cnt),
`endif
    .dbg_state_o(b_state)
  );

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int           fd_cnt = 0;
  int           acc_cyc[16];

  // Expected strobe word for pixel k (1-based raster order) of a 4x3 frame.
  function automatic logic [W-1:0] exp_pix(input int k);
    int c;
    int r;
    c = (k - 1) % 4;
    r = (k - 1) / 4;
    return {1'b1, 16'(k), 16'(c), 16'(r), (c == 0), (c == 3), (r == 0), (r == 2), (k == 12)};
  endfunction

  task automatic push_frame(input int n);
    for (int k = 1; k <= n; k++) exp_q.push_back(exp_pix(k));
  endtask

  always @(negedge clk) begin
    if (rst_n && (a_pix_en || a_frame_done)) begin
      if (a_frame_done) fd_cnt++;
      if (exp_q.size() == 0)
        check("sb_unexpected_pix", 64'(exp_q.size()), 64'd1);
      else
        check("pix", {a_pix_en, a_pix_data, a_col, a_row, a_sol, a_eol, a_first, a_last, a_frame_done},
              exp_q.pop_front());
    end
  end

  // ---------------- driver ----------------
  // Starts a frame on DUT A and offers pixels 1..n_pix; toggle drives
  // s_valid 1,0,1,0...; mid_start raises start while pixel 6 is offered.
  task automatic run_frame(input int n_pix, input bit toggle, input bit mid_start);
    int k;
    int cyc;
    bit acc;
    k = 1;
    cyc = 0;
    @(posedge clk); #1 a_start = 1'b1;
    @(posedge clk); #1 a_start = 1'b0;
    while (k <= n_pix && cyc < 200) begin
      a_if.s_valid = toggle ? (cyc % 2 == 0) : 1'b1;
      a_if.s_pixel = 16'(k);
      a_start      = mid_start && (k == 6);
      acc          = a_if.s_valid && a_if.s_ready;
      @(posedge clk); #1;
      cyc++;
      if (acc) begin
        acc_cyc[k] = cyc;
        k++;
      end
    end
    a_if.s_valid = 1'b0;
    a_start      = 1'b0;
    if (k <= n_pix) check("drv_timeout", 64'(k), 64'(n_pix + 1));
  endtask

  task automatic settle();
    repeat (4) @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin : main
    int cyc;
    a_start = 1'b0; a_if.s_valid = 1'b0; a_if.s_pixel = '0;
    b_start = 1'b0; b_if.s_valid = 1'b0; b_if.s_pixel = '0;

    // Reset values.
    #3;
    check("rst_outputs", {a_pix_en, a_pix_data, a_col, a_row, a_sol, a_eol, a_first, a_last,
                          a_frame_done, a_busy, a_if.s_ready}, 64'd0);
    check("rst_state", 64'(a_state), 64'(ST_IDLE));
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    check("idle_ready", {a_if.s_ready, a_busy}, 64'd0);

    // Frame 1: continuous s_valid.
    fd_cnt = 0;
    push_frame(12);
    run_frame(12, 1'b0, 1'b0);
    settle();
    check("f1_gap_after_4", 64'(acc_cyc[5] - acc_cyc[4]), 64'd3);
    check("f1_gap_after_8", 64'(acc_cyc[9] - acc_cyc[8]), 64'd3);
    check("f1_no_gap_in_line", 64'(acc_cyc[2] - acc_cyc[1]), 64'd1);
    check("f1_frame_done_cnt", 64'(fd_cnt), 64'd1);
    check("f1_sb_left", 64'(exp_q.size()), 64'd0);
    check("f1_idle", {a_busy, a_pix_en, a_frame_done}, 64'd0);

    // Frame 2: toggling s_valid.
    fd_cnt = 0;
    push_frame(12);
    run_frame(12, 1'b1, 1'b0);
    settle();
    check("f2_frame_done_cnt", 64'(fd_cnt), 64'd1);
    check("f2_sb_left", 64'(exp_q.size()), 64'd0);

    // Frame 3: start raised during row 1 is ignored.
    fd_cnt = 0;
    push_frame(12);
    run_frame(12, 1'b0, 1'b1);
    repeat (10) @(posedge clk);
    #1;
    check("f3_frame_done_cnt", 64'(fd_cnt), 64'd1);
    check("f3_sb_left", 64'(exp_q.size()), 64'd0);
    check("f3_no_restart", 64'(a_busy), 64'd0);

    // Frame 4: reset after pixel 6, while its strobe is still high.
    fd_cnt = 0;
    push_frame(6);
    run_frame(6, 1'b0, 1'b0);
    #6;
    check("f4_sb_before_rst", 64'(exp_q.size()), 64'd0);
    rst_n = 1'b0;
    #1;
    check("f4_rst_outputs", {a_pix_en, a_pix_data, a_col, a_row, a_sol, a_eol, a_first, a_last,
                             a_frame_done, a_busy, a_if.s_ready}, 64'd0);
    check("f4_rst_state", 64'(a_state), 64'(ST_IDLE));
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("f4_no_frame_done", 64'(fd_cnt), 64'd0);
    check("f4_stay_idle", 64'(a_busy), 64'd0);
    push_frame(12);
    run_frame(12, 1'b0, 1'b0);
    settle();
    check("f4_restart_done_cnt", 64'(fd_cnt), 64'd1);
    check("f4_sb_left", 64'(exp_q.size()), 64'd0);

    // 1x1 frame on DUT B.
    @(posedge clk); #1;
    b_start = 1'b1;
    b_if.s_valid = 1'b1;
    b_if.s_pixel = 16'hABCD;
    @(posedge clk); #1 b_start = 1'b0;
    cyc = 0;
    while (!b_pix_en && cyc < 10) begin
      @(posedge clk); #1;
      cyc++;
    end
    b_if.s_valid = 1'b0;
    check("b_single_pix", {b_pix_en, b_pix_data, b_col, b_row, b_sol, b_eol, b_first, b_last, b_frame_done},
          {1'b1, 16'hABCD, 16'd0, 16'd0, 4'hF, 1'b1});
    check("b_latency", 64'(cyc), 64'd1);
    @(posedge clk); #1;
    check("b_after", {b_pix_en, b_frame_done, b_busy, b_sol, b_eol}, 64'd0);

`ifdef JLS_SCAN_CTRL_FRAME_CNT_EN
    // Frame counter wraps from 65535 to 0.
    force dut_a.frame_cnt_q = 16'hFFFF;
    @(posedge clk); #1;
    release dut_a.frame_cnt_q;
    check("fcnt_preload", 64'(a_frame_cnt), 64'hFFFF);
    fd_cnt = 0;
    push_frame(12);
    run_frame(12, 1'b0, 1'b0);
    settle();
    check("fcnt_wrap", 64'(a_frame_cnt), 64'd0);
    check("fcnt_sb_left", 64'(exp_q.size()), 64'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    n_fail++;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

endmodule
